// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and widths for the boot loader
package boot_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - streams a length-prefixed big-endian image into word RAM, then hands the RAM port to the processor
module boot_loader
  import boot_pkg::*;
#(
  parameter int MAX_WORDS = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [WORD_W-1:0] proc_dout,
  input  logic              proc_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_din,
  output logic              mem_we,
  output logic              proc_hold,
  output logic              error
);

  // 17-bit so that a full 65536-word image is representable
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state, state_nx;
  logic [16:0] count;
  logic [16:0] wr_ptr;
  logic [16:0] wr_next;
  logic [16:0] hdr_n;
  logic [WORD_W-1:0] word;
  logic        xfer;

  assign xfer    = rx_valid & rx_ready;
  assign hdr_n   = {1'b0, count[15:8], rx_data};
  assign wr_next = wr_ptr + 17'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= CNT_HI;
      count  <= '0;
      wr_ptr <= '0;
      word   <= '0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        case (state)
          CNT_HI:  count       <= {1'b0, rx_data, 8'h00};
          CNT_LO:  count[7:0]  <= rx_data;
          DATA_HI: word[15:8]  <= rx_data;
          DATA_LO: word[7:0]   <= rx_data;
          default: ;
        endcase
      end
      if (state == WRITE)
        wr_ptr <= wr_next;
    end
  end

  always_comb begin
    state_nx  = state;
    rx_ready  = 1'b0;
    proc_hold = 1'b1;
    error     = 1'b0;
    mem_addr  = wr_ptr[ADDR_W-1:0];
    mem_din   = word;
    mem_we    = 1'b0;
    case (state)
      CNT_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nx = CNT_LO;
      end
      CNT_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (hdr_n == 17'd0)
            state_nx = DONE;
          else if (hdr_n > MAX_N)
            state_nx = ERROR;
          else
            state_nx = DATA_HI;
        end
      end
      DATA_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nx = DATA_LO;
      end
      DATA_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nx = WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        state_nx = (wr_next == count) ? DONE : DATA_HI;
      end
      DONE: begin
        // zero-latency pass-through once the image is in place
        proc_hold = 1'b0;
        mem_addr  = proc_addr;
        mem_din   = proc_dout;
        mem_we    = proc_we;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: state_nx = CNT_HI;
    endcase
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - scoreboard bench for boot_loader
module tb_boot_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rx_valid, rx_ready, proc_we, mem_we, proc_hold, error;
  logic [7:0]  rx_data;
  logic [15:0] proc_addr, proc_dout, mem_addr, mem_din;

  logic        s_reset, s_rx_valid, s_rx_ready, s_proc_we, s_mem_we, s_proc_hold, s_error;
  logic [7:0]  s_rx_data;
  logic [15:0] s_proc_addr, s_proc_dout, s_mem_addr, s_mem_din;

  boot_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .proc_addr(proc_addr), .proc_dout(proc_dout), .proc_we(proc_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .proc_hold(proc_hold), .error(error)
  );

  boot_loader #(.MAX_WORDS(4)) dut_small (
    .clk(clk), .reset(s_reset), .rx_data(s_rx_data), .rx_valid(s_rx_valid), .rx_ready(s_rx_ready),
    .proc_addr(s_proc_addr), .proc_dout(s_proc_dout), .proc_we(s_proc_we),
    .mem_addr(s_mem_addr), .mem_din(s_mem_din), .mem_we(s_mem_we),
    .proc_hold(s_proc_hold), .error(s_error)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0, t;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && proc_hold && mem_we) begin
      if (exp_q.size() == 0)
        check_eq("unexpected_we", {mem_addr, mem_din}, 32'h0);
      else begin
        mon_e = exp_q.pop_front();
        check_eq("ram_write", {mem_addr, mem_din}, mon_e);
      end
    end
    if (s_reset && s_proc_hold && s_mem_we)
      check_eq("small_unexpected_we", 1, 0);
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (rx_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0)
      check_eq("rx_timeout", 0, 1);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int addr, input int maxgap);
    int a;
    logic [15:0] ad;
    ad = addr[15:0];
    exp_q.push_back({ad, w});
    send_byte(w[15:8], $urandom_range(maxgap, 0), a);
    send_byte(w[7:0], $urandom_range(maxgap, 0), a);
  endtask

  task automatic wait_release(output int when);
    when = -1;
    for (int i = 0; i < 60; i++) begin
      if (!proc_hold) begin
        when = cyc;
        break;
      end
      @(negedge clk);
    end
    if (when < 0) check_eq("release_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_hold", proc_hold, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; rx_valid = 1'b0; rx_data = '0;
    proc_addr = '0; proc_dout = '0; proc_we = 1'b0;
    s_reset = 1'b0; s_rx_valid = 1'b0; s_rx_data = '0;
    s_proc_addr = '0; s_proc_dout = '0; s_proc_we = 1'b0;
    #2;
    check_eq("rst_proc_hold", proc_hold, 1);
    check_eq("rst_rx_ready", rx_ready, 1);
    check_eq("rst_error", error, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_din", mem_din, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; s_reset = 1'b1;
    @(negedge clk);

    // N=3 back-to-back
    send_byte(8'h00, 0, t0);
    send_byte(8'h03, 0, t);
    send_word(16'h1234, 0, 0);
    send_word(16'hABCD, 1, 0);
    send_word(16'h0001, 2, 0);
    rx_valid = 1'b0;
    wait_release(t);
    check_eq("n3_release_cycles", t - t0, 11);
    check_eq("n3_all_written", exp_q.size(), 0);

    // N=0
    pulse_reset();
    send_byte(8'h00, 0, t);
    send_byte(8'h00, 0, t);
    rx_valid = 1'b0;
    check_eq("n0_hold", proc_hold, 0);
    check_eq("n0_rx_ready", rx_ready, 0);
    rx_data = 8'h12; rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("n0_late_ready", rx_ready, 0);
    check_eq("n0_still_done", proc_hold, 0);
    check_eq("n0_no_we", mem_we, 0);
    rx_valid = 1'b0;

    // N=2 with random gaps
    pulse_reset();
    send_byte(8'h00, $urandom_range(5, 0), t);
    send_byte(8'h02, $urandom_range(5, 0), t);
    send_word(16'hCAFE, 0, 5);
    send_word(16'h0F0F, 1, 5);
    rx_valid = 1'b0;
    wait_release(t);
    check_eq("gap_all_written", exp_q.size(), 0);
    check_eq("gap_hold", proc_hold, 0);

    // reset after three body bytes, then a fresh image
    pulse_reset();
    send_byte(8'h00, 0, t);
    send_byte(8'h05, 0, t);
    send_word(16'h1122, 0, 0);
    send_byte(8'h33, 0, t);
    rx_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_hold", proc_hold, 1);
    check_eq("mid_rst_ready", rx_ready, 1);
    check_eq("mid_rst_we", mem_we, 0);
    check_eq("mid_rst_addr", mem_addr, 0);
    check_eq("mid_rst_din", mem_din, 0);
    check_eq("mid_rst_error", error, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_first_written", exp_q.size(), 0);
    send_byte(8'h00, 0, t);
    send_byte(8'h01, 0, t);
    send_word(16'hBEEF, 0, 0);
    rx_valid = 1'b0;
    wait_release(t);
    check_eq("beef_written", exp_q.size(), 0);

    // pass-through in DONE
    proc_addr = 16'h0042; proc_dout = 16'h5555; proc_we = 1'b1;
    #1;
    check_eq("pt_addr", mem_addr, 16'h0042);
    check_eq("pt_din", mem_din, 16'h5555);
    check_eq("pt_we", mem_we, 1);
    rx_data = 8'hAA; rx_valid = 1'b1;
    @(negedge clk);
    check_eq("pt_rx_ready", rx_ready, 0);
    check_eq("pt_hold", proc_hold, 0);
    proc_addr = 16'h0100; proc_we = 1'b0;
    #1;
    check_eq("pt_addr2", mem_addr, 16'h0100);
    check_eq("pt_we2", mem_we, 0);
    rx_valid = 1'b0;

    // MAX_WORDS=4: header 5 rejected, header 4 accepted
    @(negedge clk);
    s_rx_data = 8'h00; s_rx_valid = 1'b1;
    @(negedge clk);
    s_rx_data = 8'h05;
    @(negedge clk);
    check_eq("err_flag", s_error, 1);
    check_eq("err_hold", s_proc_hold, 1);
    check_eq("err_ready", s_rx_ready, 0);
    check_eq("err_we", s_mem_we, 0);
    repeat (4) @(negedge clk);
    check_eq("err_sticky", s_error, 1);
    s_rx_valid = 1'b0;
    s_reset = 1'b0;
    #1;
    check_eq("err_cleared", s_error, 0);
    @(negedge clk);
    s_reset = 1'b1;
    @(negedge clk);
    s_rx_data = 8'h00; s_rx_valid = 1'b1;
    @(negedge clk);
    s_rx_data = 8'h04;
    @(negedge clk);
    s_rx_valid = 1'b0;
    check_eq("max_ok_error", s_error, 0);
    check_eq("max_ok_ready", s_rx_ready, 1);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Loads a program image into the shared 16-bit word RAM before the processor runs. It accepts a byte stream on a valid/ready interface, assembles big-endian 16-bit words, and writes them to consecutive RAM addresses from 0. While loading, it holds the processor and owns the RAM port. Afterwards it passes the processor's memory signals straight through, so it sits between the processor and the RAM in the system.

## Interface
- MAX_WORDS, 65536: largest accepted image size in words; legal range 1..65536.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming image byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both 1 at a rising edge.
- proc_addr  in  16  processor address.
- proc_dout  in  16  processor write data.
- proc_we  in  1  processor write enable.
- mem_addr  out  16  RAM address.
- mem_din  out  16  RAM write data.
- mem_we  out  1  RAM write enable.
- proc_hold  out  1  1 = processor held in reset; tie to the processor reset.
- error  out  1  sticky flag: the image header was rejected.

## Operation
- Image format:
  - Header: count N as 2 bytes, high byte first.
  - Body: N words, each as 2 bytes, high byte first.
- Word address starts at 0 and increments by 1 per word.
- State machine (states in package):
  - CNT_HI: accept a byte into count[15:8], then go to CNT_LO.
  - CNT_LO: accept a byte into count[7:0]. Next state:
    - N == 0 → DONE.
    - N > MAX_WORDS → ERROR.
    - otherwise → DATA_HI.
  - DATA_HI: accept a byte into word[15:8], then go to DATA_LO.
  - DATA_LO: accept a byte into word[7:0], then go to WRITE.
  - WRITE: one cycle with mem_we=1, mem_addr=wr_ptr, mem_din=word. Then wr_ptr increments.
    - If the word just written is number N → DONE.
    - otherwise → DATA_HI.
  - DONE: terminal until reset.
  - ERROR: terminal until reset; error=1.
- rx_ready is 1 in CNT_HI, CNT_LO, DATA_HI and DATA_LO only; it is 0 in WRITE, DONE and ERROR.
- Bytes offered while rx_ready=0 are not consumed and do not change state.
- Port multiplexing:
  - proc_hold=1 in every state except DONE.
  - While proc_hold=1, mem_* come from the loader. mem_we is 1 only in WRITE, and proc_we is ignored.
  - In DONE: mem_addr=proc_addr, mem_din=proc_dout, mem_we=proc_we. This path is combinational with zero latency.
- Width rules:
  - count is 17-bit internally so that MAX_WORDS=65536 is representable.
  - wr_ptr is 17-bit; mem_addr takes wr_ptr[15:0].
  - No wrap-around can occur because N ≤ MAX_WORDS ≤ 65536.

## Timing
- Values while reset=0, immediately and asynchronously:
  - state=CNT_HI, wr_ptr=0, count=0, word=0.
  - proc_hold=1, error=0, rx_ready=1, mem_we=0, mem_addr=0, mem_din=0.
- Per word: at least 3 cycles (DATA_HI, DATA_LO, WRITE). With rx_valid held at 1, the image loads in 2 + 3N cycles.
- Stalls: rx_valid gaps stretch DATA_HI and DATA_LO with no other effect.
- Release:
  - proc_hold falls in the cycle after the last WRITE cycle.
  - For N=0, proc_hold falls in the cycle after the CNT_LO byte is accepted.
- Reset mid-load:
  - Partial data is discarded and the header must be resent.
  - RAM contents already written are left unchanged.
- Reset in DONE: returns to CNT_HI and holds the processor again.

## Structure
- Shared package boot_pkg:
  - State enum: CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR.
  - BYTE_W=8, WORD_W=16, ADDR_W=16.
- Single module, no sub-module. The system top instantiates it between the processor and the RAM.

## Test plan
- N=3 with bytes 00 03 12 34 AB CD 00 01 streamed back-to-back:
  - writes 0x1234@0, 0xABCD@1, 0x0001@2.
  - each write has mem_we high for exactly 1 cycle.
  - proc_hold falls 11 cycles after the first byte is accepted.
- N=0 (bytes 00 00):
  - no mem_we pulse.
  - proc_hold=0 on the next cycle.
  - later bytes see rx_ready=0.
- MAX_WORDS=4 with header 00 05:
  - error=1, proc_hold stays 1, rx_ready=0, no writes.
  - error clears only on reset.
- N=2 with random rx_valid gaps of 0–5 cycles:
  - same writes as gap-free.
  - no byte is lost or duplicated.
- Reset asserted after 3 body bytes:
  - outputs take their reset values immediately.
  - a fresh image 00 01 BE EF then writes 0xBEEF@0.
- In DONE, drive proc_addr=0x0042, proc_dout=0x5555, proc_we=1:
  - mem_addr, mem_din and mem_we mirror these in the same cycle.
  - rx_valid bytes are ignored.
